// File: rtl/subset_coord_reader.sv
// subset_coord_reader
//
// Consumer end of the subset-coordinate bus. When the coordinate generator
// raises sub_done (low->high), the packed float32 x/y arrays, the image width
// and the base address are captured. Each point is then converted to integer
// pixel coordinates and one linear image-memory address per point is streamed
// out over a valid/ready handshake.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   x, y         packed float32 coordinates, point k at [32k+31:32k]
//   sub_done     generator completion level (sticky high once set)
//   image_width  pixels per image row, captured with x/y
//   base_addr    image base address, captured with x/y
//   addr         base_addr + pix_y*image_width + pix_x (mod 2^32)
//   pix_x/pix_y  converted coordinates of the current point
//   index        current point number
//   clip         current point had a negative or saturated conversion
//   last         marks the final beat of a run
//   addr_valid   address beat valid
//   addr_ready   downstream accepts the beat
//   busy         high whenever not idle
//   read_done    one-cycle pulse after the last beat is accepted

module subset_coord_reader #(
  parameter int NUM_POINTS = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [32*NUM_POINTS-1:0] x,
  input  logic [32*NUM_POINTS-1:0] y,
  input  logic                    sub_done,
  input  logic [15:0]             image_width,
  input  logic [31:0]             base_addr,
  output logic [31:0]             addr,
  output logic [15:0]             pix_x,
  output logic [15:0]             pix_y,
  output logic [3:0]              index,
  output logic                    clip,
  output logic                    last,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic                    busy,
  output logic                    read_done
);

  typedef enum logic [2:0] {
    IDLE,
    CONV_X,
    CONV_Y,
    CALC,
    EMIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                     sd_q, sd_d;
  logic [32*NUM_POINTS-1:0] xBus_q, xBus_d;
  logic [32*NUM_POINTS-1:0] yBus_q, yBus_d;
  logic [15:0]              width_q, width_d;
  logic [31:0]              base_q, base_d;
  logic [31:0]              addr_q, addr_d;
  logic [15:0]              pixX_q, pixX_d;
  logic [15:0]              pixY_q, pixY_d;
  logic [3:0]               index_q, index_d;
  logic                     clipX_q, clipX_d;
  logic                     clipY_q, clipY_d;
  logic                     clip_q, clip_d;
  logic                     last_q, last_d;
  logic                     valid_q, valid_d;

  logic        trigger;
  logic [31:0] curX;
  logic [31:0] curY;
  logic [16:0] convX;
  logic [16:0] convY;
  logic [31:0] rowOffset;

  // Float32 to unsigned 16-bit pixel conversion, truncating toward zero.
  // Returns {clip, value}. Exponents above 142 (including NaN/Inf) saturate.
  // In the in-range case the shift is at least 8, so the result fits 16 bits.
  function automatic logic [16:0] floatToPix(input logic [31:0] f);
    logic [7:0]  e;
    logic [23:0] m;
    logic [7:0]  sh;
    e  = f[30:23];
    m  = {1'b1, f[22:0]};
    sh = 8'd150 - e;
    if (f[30:0] == 31'd0)
      floatToPix = 17'd0;
    else if (f[31])
      floatToPix = {1'b1, 16'd0};
    else if (e < 8'd127)
      floatToPix = 17'd0;
    else if (e > 8'd142)
      floatToPix = {1'b1, 16'hFFFF};
    else
      floatToPix = {1'b0, 16'(m >> sh)};
  endfunction

  // A run starts only on a genuine low->high transition; sd_q resets high so
  // a level held across reset cannot start a run.
  assign trigger = sub_done & ~sd_q;

  assign curX  = xBus_q[index_q*32 +: 32];
  assign curY  = yBus_q[index_q*32 +: 32];
  assign convX = floatToPix(curX);
  assign convY = floatToPix(curY);

  // 16x16 multiply widened to 32 bits is exact; the add wraps mod 2^32.
  assign rowOffset = {16'd0, pixY_q} * {16'd0, width_q};

  // Next-state and datapath update. Everything holds by default so beat
  // outputs stay frozen while EMIT waits for the downstream.
  always_comb begin
    state_d = state_q;
    sd_d    = sub_done;
    xBus_d  = xBus_q;
    yBus_d  = yBus_q;
    width_d = width_q;
    base_d  = base_q;
    addr_d  = addr_q;
    pixX_d  = pixX_q;
    pixY_d  = pixY_q;
    index_d = index_q;
    clipX_d = clipX_q;
    clipY_d = clipY_q;
    clip_d  = clip_q;
    last_d  = last_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          xBus_d  = x;
          yBus_d  = y;
          width_d = image_width;
          base_d  = base_addr;
          index_d = 4'd0;
          state_d = CONV_X;
        end
      end
      CONV_X: begin
        pixX_d  = convX[15:0];
        clipX_d = convX[16];
        state_d = CONV_Y;
      end
      CONV_Y: begin
        pixY_d  = convY[15:0];
        clipY_d = convY[16];
        state_d = CALC;
      end
      CALC: begin
        addr_d  = base_q + rowOffset + {16'd0, pixX_q};
        clip_d  = clipX_q | clipY_q;
        last_d  = (index_q == 4'(NUM_POINTS - 1));
        valid_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (valid_q && addr_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (index_q < 4'(NUM_POINTS - 1)) begin
            index_d = index_q + 4'd1;
            state_d = CONV_X;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any same-cycle event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sd_q    <= 1'b1;
      xBus_q  <= '0;
      yBus_q  <= '0;
      width_q <= 16'd0;
      base_q  <= 32'd0;
      addr_q  <= 32'd0;
      pixX_q  <= 16'd0;
      pixY_q  <= 16'd0;
      index_q <= 4'd0;
      clipX_q <= 1'b0;
      clipY_q <= 1'b0;
      clip_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sd_q    <= sd_d;
      xBus_q  <= xBus_d;
      yBus_q  <= yBus_d;
      width_q <= width_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      pixX_q  <= pixX_d;
      pixY_q  <= pixY_d;
      index_q <= index_d;
      clipX_q <= clipX_d;
      clipY_q <= clipY_d;
      clip_q  <= clip_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign addr       = addr_q;
  assign pix_x      = pixX_q;
  assign pix_y      = pixY_q;
  assign index      = index_q;
  assign clip       = clip_q;
  assign last       = last_q;
  assign addr_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign read_done  = (state_q == DONE);

endmodule

// File: doc/subset_coord_reader.md
# subset_coord_reader

Consumer end of the subset-coordinate bus. Captures the packed float32 x/y coordinate arrays when the coordinate generator raises `sub_done`, converts each point to integer pixel coordinates, and streams one linear image-memory address per point over a valid/ready handshake. It sits between the subset coordinate generator and the image-intensity fetch logic.

## Interface
- `NUM_POINTS`, 9: number of points on the bus (3×3 subset). Bus width is 32·NUM_POINTS.
- `clock`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `x`  in  288  packed float32 x coordinates; point k occupies bits [32k+31:32k].
- `y`  in  288  packed float32 y coordinates, same packing.
- `sub_done`  in  1  generator completion flag; level, sticky high once set.
- `image_width`  in  16  pixels per image row; sampled with x/y.
- `base_addr`  in  32  image base address; sampled with x/y.
- `addr`  out  32  `base_addr + pix_y*image_width + pix_x`, mod 2^32.
- `pix_x`, `pix_y`  out  16 each  converted integer coordinates of the current point.
- `index`  out  4  current point number, 0..NUM_POINTS-1.
- `clip`  out  1  current point had a negative or saturated conversion.
- `last`  out  1  high with `addr_valid` when `index == NUM_POINTS-1`.
- `addr_valid`  out  1  address beat valid.
- `addr_ready`  in  1  downstream accepts the beat.
- `busy`  out  1  high in every state except IDLE.
- `read_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Rising-edge detect on `sub_done`: register `sd_q` holds the previous sample and resets to 1. A trigger requires `sub_done` to be low, then high. A level held high across reset therefore does not retrigger.
- States: IDLE, CONV_X, CONV_Y, CALC, EMIT, DONE.
- IDLE:
  - On a trigger, latch `x`, `y`, `image_width` and `base_addr`.
  - Set `index` = 0 and go to CONV_X.
  - `sub_done` edges outside IDLE are ignored.
- CONV_X converts x[index] to `pix_x`, then goes to CONV_Y. CONV_Y converts y[index] to `pix_y`, then goes to CALC.
- CALC: registers `addr`, `clip` and `last`, sets `addr_valid` = 1, goes to EMIT.
- EMIT: holds all outputs stable until `addr_valid && addr_ready` at a clock edge. On that edge:
  - Clear `addr_valid`.
  - If `index < NUM_POINTS-1`: increment `index`, go to CONV_X.
  - Otherwise: go to DONE.
- DONE: assert `read_done` for exactly one cycle, then go to IDLE.
- Float-to-int conversion. Fields: e = f[30:23], m = {1, f[22:0]}.
  - f[30:0] == 0 (±0): result 0, no clip.
  - f[31] == 1 and nonzero: result 0, clip.
  - e < 127 (|f| < 1): result 0, no clip.
  - e > 142 (≥ 65536): result 0xFFFF, clip.
  - Otherwise: result = m >> (150−e), truncated toward zero.
  - NaN and Inf fall under the e > 142 rule.
- Address arithmetic: 16×16 unsigned multiply to 32 bits, then 32-bit add wrapping modulo 2^32.
- `clip` = clip(x) OR clip(y) for the current point.

## Timing
- Reset values: every output 0; state IDLE; `sd_q` = 1.
- Let E0 be the edge that detects the trigger and latches the inputs. CONV_X runs at E1, CONV_Y at E2, CALC at E3. `addr_valid` is visible after E3.
- Per point: 3 cycles with `addr_valid` low, then EMIT lasts ≥ 1 cycle.
- Minimum run with `addr_ready` tied high: 4·NUM_POINTS cycles, plus 1 DONE cycle carrying `read_done`.
- `addr_valid` never depends combinationally on `addr_ready`.
- While `addr_valid` is high, `addr`, `pix_x`, `pix_y`, `index`, `clip` and `last` do not change.
- Reset mid-operation: state goes to IDLE at that edge, `addr_valid` drops, and `read_done` is not pulsed. A new run needs a fresh low→high on `sub_done`.
- `reset` has priority over all events in the same cycle.

## Test plan
- All x = 0x41100000 (9.0), all y = 0x41980000 (19.0), width 640, base 0, ready high -> 9 beats with addr = 12169, `clip` = 0; `last` only on index 8; `read_done` 37 cycles after E0.
- x[0] = 0x40300000 (2.75), y[0] = 0xC0400000 (−3.0) -> point 0: pix_x = 2, pix_y = 0, clip = 1, addr = base + 2.
- x[1] = 0x4788B800 (70000.0), y[1] = 0x3F000000 (0.5) -> pix_x = 0xFFFF, pix_y = 0, clip = 1.
- Hold `addr_ready` low 5 cycles during beat 3 -> `addr_valid` and all beat outputs constant; beat accepted on the first ready edge; `index` advances only after that edge.
- Assert `reset` for 1 cycle while in EMIT at index 4 -> outputs 0, no `read_done`. With `sub_done` still high there is no restart. Drive `sub_done` low for 1 cycle, then high -> new run begins at index 0.
- Base 0xFFFFFFF0, width 640, x = y = 1.0 -> addr = 0x00000271 (wrap).
